// File: rtl/branch_cmp_seq.sv
// Multicycle RV32I branch comparator: one CHUNK-wide slice per cycle, MSB slice first.
// Define BRCMP_EARLY_EXIT_EN to finish at the first differing slice; otherwise all slices run.
module branch_cmp_seq #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] rd1,
    input  logic [WIDTH-1:0] rd2,
    output logic             busy,
    output logic             done,
    output logic             taken,
    output logic             eq,
    output logic             lt
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    typedef enum logic [1:0] {
        IDLE,
        CMP,
        DONE
    } state_t;

    state_t state, next_state;

    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] msb_flip;
    logic [2:0]       f3_q;
    logic [IDXW-1:0]  idx;
    logic [CHUNK-1:0] a_slc, b_slc;
    logic             slc_ne, slc_lt, last;
    logic             accept, decide, dec_eq, dec_lt, dec_taken;
    logic             eq_q, lt_q, taken_q;
`ifndef BRCMP_EARLY_EXIT_EN
    logic             found_q, found_lt_q;
`endif

    // Flipping the sign bit maps two's-complement order onto unsigned order.
    always_comb begin
        msb_flip = '0;
        msb_flip[WIDTH-1] = (funct3[2:1] != 2'b11);
    end

    always_comb begin
        int lo;
        lo     = (NCHUNK - 1 - int'(idx)) * CHUNK;
        a_slc  = a_q[lo +: CHUNK];
        b_slc  = b_q[lo +: CHUNK];
        slc_ne = (a_slc != b_slc);
        slc_lt = (a_slc < b_slc);
        last   = (idx == LAST_IDX);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        decide     = 1'b0;
        dec_eq     = 1'b0;
        dec_lt     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    next_state = CMP;
                end
            end
            CMP: begin
`ifdef BRCMP_EARLY_EXIT_EN
                if (slc_ne) begin
                    decide = 1'b1;
                    dec_lt = slc_lt;
                end else if (last) begin
                    decide = 1'b1;
                    dec_eq = 1'b1;
                end
`else
                // The first differing slice wins; later slices only matter if none differed yet.
                if (last) begin
                    decide = 1'b1;
                    dec_eq = !found_q && !slc_ne;
                    dec_lt = found_q ? found_lt_q : slc_lt;
                end
`endif
                if (decide) next_state = DONE;
            end
            DONE: begin
                if (start) begin
                    accept     = 1'b1;
                    next_state = CMP;
                end else begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        case (f3_q)
            3'b000:         dec_taken = dec_eq;
            3'b001:         dec_taken = !dec_eq;
            3'b100, 3'b110: dec_taken = dec_lt;
            3'b101, 3'b111: dec_taken = !dec_lt;
            default:        dec_taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            f3_q    <= '0;
            idx     <= '0;
            eq_q    <= 1'b0;
            lt_q    <= 1'b0;
            taken_q <= 1'b0;
`ifndef BRCMP_EARLY_EXIT_EN
            found_q    <= 1'b0;
            found_lt_q <= 1'b0;
`endif
        end else begin
            if (accept) begin
                a_q  <= rd1 ^ msb_flip;
                b_q  <= rd2 ^ msb_flip;
                f3_q <= funct3;
                idx  <= '0;
`ifndef BRCMP_EARLY_EXIT_EN
                found_q <= 1'b0;
`endif
            end else if (state == CMP) begin
                if (!decide) idx <= idx + IDXW'(1);
`ifndef BRCMP_EARLY_EXIT_EN
                if (slc_ne && !found_q) begin
                    found_q    <= 1'b1;
                    found_lt_q <= slc_lt;
                end
`endif
            end
            if (decide) begin
                eq_q    <= dec_eq;
                lt_q    <= dec_lt;
                taken_q <= dec_taken;
            end
        end
    end

    assign busy  = (state == CMP);
    assign done  = (state == DONE);
    assign eq    = eq_q;
    assign lt    = lt_q;
    assign taken = taken_q;

endmodule

// File: tb/tb_branch_cmp_seq.sv
// Bench for branch_cmp_seq: transaction-level model checked every cycle plus directed literal cases.
module tb_branch_cmp_seq;

    localparam int WIDTH  = 32;
    localparam int CHUNK  = 8;
    localparam int NCHUNK = WIDTH / CHUNK;
`ifdef BRCMP_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [2:0]       funct3;
    logic [WIDTH-1:0] rd1, rd2;
    logic             busy, done, taken, eq, lt;

    int n_checks = 0;
    int n_pass   = 0;

    branch_cmp_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk(clk), .rst(rst), .start(start), .funct3(funct3),
        .rd1(rd1), .rd2(rd2), .busy(busy), .done(done),
        .taken(taken), .eq(eq), .lt(lt)
    );

    always #5 clk = ~clk;

    task automatic chk_b(input string name, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    endtask

    task automatic chk_i(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    function automatic logic f_lt(input logic [2:0] f, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        if (f[2:1] == 2'b11) return a < b;
        return $signed(a) < $signed(b);
    endfunction

    function automatic logic f_taken(input logic [2:0] f, input logic e, input logic l);
        case (f)
            3'b000: return e;
            3'b001: return !e;
            3'b100, 3'b110: return l;
            3'b101, 3'b111: return !l;
            default: return 1'b0;
        endcase
    endfunction

    // Cycles from accept to DONE: position of the highest differing bit picks the slice.
    function automatic int f_lat(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] x;
        int p;
        if (!EE || a == b) return NCHUNK;
        x = a ^ b;
        p = 0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (x[i]) begin
                p = i;
                break;
            end
        end
        return (WIDTH - 1 - p) / CHUNK + 1;
    endfunction

    int   m_rem;
    logic m_done, m_eq, m_lt, m_taken;
    logic p_eq, p_lt, p_taken;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_rem <= 0; m_done <= 1'b0;
            m_eq <= 1'b0; m_lt <= 1'b0; m_taken <= 1'b0;
        end else begin
            m_done <= (m_rem == 1);
            if (m_rem == 1) begin
                m_eq <= p_eq; m_lt <= p_lt; m_taken <= p_taken;
            end
            if (m_rem > 0) begin
                m_rem <= m_rem - 1;
            end else if (start) begin
                m_rem   <= f_lat(rd1, rd2);
                p_eq    <= (rd1 == rd2);
                p_lt    <= f_lt(funct3, rd1, rd2);
                p_taken <= f_taken(funct3, rd1 == rd2, f_lt(funct3, rd1, rd2));
            end
        end
    end

    always @(negedge clk) begin
        chk_b("busy",  busy,  m_rem > 0);
        chk_b("done",  done,  m_done);
        chk_b("eq",    eq,    m_eq);
        chk_b("lt",    lt,    m_lt);
        chk_b("taken", taken, m_taken);
    end

    // ---------------- directed stimulus ----------------
    // Called at a negedge; returns at the negedge where done is high.
    task automatic do_op(input string name, input logic [2:0] f, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input int hold,
                         input logic et, input logic ee, input logic el, input int elat);
        int lat;
        lat = -1;
        start = 1'b1; funct3 = f; rd1 = a; rd2 = b;
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            if (j == hold) begin
                start = 1'b0;
            end else if (j < hold) begin
                rd1 = ~a; rd2 = b ^ 32'h5A5A_5A5A; funct3 = 3'b001;
            end
            if (done) begin
                lat = j;
                break;
            end
        end
        start = 1'b0;
        chk_i({name, "_latency"}, lat, elat);
        chk_b({name, "_taken"}, taken, et);
        chk_b({name, "_eq"}, eq, ee);
        chk_b({name, "_lt"}, lt, el);
        chk_b({name, "_model_taken"}, m_taken, et);
        chk_b({name, "_model_eq"}, m_eq, ee);
        chk_b({name, "_model_lt"}, m_lt, el);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; funct3 = 3'b000; rd1 = '0; rd2 = '0;
        repeat (2) @(negedge clk);
        chk_b("reset_busy", busy, 1'b0);
        chk_b("reset_done", done, 1'b0);
        chk_b("reset_taken", taken, 1'b0);
        chk_b("reset_eq", eq, 1'b0);
        chk_b("reset_lt", lt, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        do_op("beq_equal", 3'b000, 32'h1234_5678, 32'h1234_5678, 0, 1'b1, 1'b1, 1'b0, 4);
        @(negedge clk);
        do_op("blt_neg", 3'b100, 32'hFFFF_FFFF, 32'h0000_0001, 0, 1'b1, 1'b0, 1'b1, EE ? 1 : 4);
        @(negedge clk);
        do_op("bltu_big", 3'b110, 32'hFFFF_FFFF, 32'h0000_0001, 0, 1'b0, 1'b0, 1'b0, EE ? 1 : 4);
        @(negedge clk);
        do_op("bgeu_slice2", 3'b111, 32'h0000_0100, 32'h0000_00FF, 0, 1'b1, 1'b0, 1'b0, EE ? 3 : 4);
        @(negedge clk);
        // back-to-back: second start issued while the first result is in DONE
        do_op("b2b_first", 3'b100, 32'hFFFF_FFFF, 32'h0000_0001, 0, 1'b1, 1'b0, 1'b1, EE ? 1 : 4);
        do_op("b2b_bne", 3'b001, 32'd5, 32'd5, 0, 1'b0, 1'b1, 1'b0, 4);
        @(negedge clk);
        do_op("funct3_010", 3'b010, 32'd3, 32'd7, 0, 1'b0, 1'b0, 1'b1, 4);
        @(negedge clk);
        do_op("start_held", 3'b000, 32'h1234_5678, 32'h1234_5678, 2, 1'b1, 1'b1, 1'b0, 4);
        @(negedge clk);

        // abort in the second CMP cycle
        start = 1'b1; funct3 = 3'b000; rd1 = 32'hA5A5_A5A5; rd2 = 32'hA5A5_A5A5;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk_b("abort_busy", busy, 1'b0);
        chk_b("abort_done", done, 1'b0);
        chk_b("abort_taken", taken, 1'b0);
        chk_b("abort_eq", eq, 1'b0);
        chk_b("abort_lt", lt, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk_b("no_done_after_abort", done, 1'b0);
        end
        do_op("bge_after_abort", 3'b101, 32'hFFFF_FFFB, 32'd3, 0, 1'b0, 1'b0, 1'b1, EE ? 1 : 4);
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/branch_cmp_seq.md
# branch_cmp_seq

Parametrised, multicycle branch comparator for the multicycle datapath. It takes two register-file operands (RD1/RD2) plus the branch funct3 and produces the branch decision over several cycles. It compares one CHUNK-wide slice per cycle, most-significant slice first, and indicates completion with a start/done handshake. It covers all six RV32I branch conditions, signed and unsigned, and the control FSM samples the decision in its branch-resolve state.

## Interface
Parameters:
- WIDTH, 32, operand width in bits.
- CHUNK, 8, bits compared per cycle. WIDTH % CHUNK == 0 is required; NCHUNK = WIDTH/CHUNK.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request a comparison. Accepted only when state is IDLE or DONE.
- funct3  in  3  branch type: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU.
- rd1  in  WIDTH  operand A, sampled on the accepting edge.
- rd2  in  WIDTH  operand B, sampled on the accepting edge.
- busy  out  1  high while state is CMP.
- done  out  1  one-cycle pulse when a result becomes valid.
- taken  out  1  branch decision.
- eq  out  1  rd1 == rd2.
- lt  out  1  rd1 < rd2, signed or unsigned as selected by funct3.

## Operation
- States:
  - IDLE: reset state.
  - CMP: one slice compared per cycle.
  - DONE: lasts exactly one cycle, then goes to IDLE unless start is high.
- On accept:
  - Latch rd1, rd2 and funct3; clear the slice index; go to CMP.
  - Signed modes (funct3[2:1] != 11): invert bit WIDTH-1 of both latched operands. A single unsigned compare is then used for every mode.
- CMP cycle i (i = 0 is slice [WIDTH-1 -: CHUNK]):
  - Slices differ: the result is decided. lt = (A slice < B slice), eq = 0.
  - Slices equal and i == NCHUNK-1: the result is decided. eq = 1, lt = 0.
  - Otherwise: i++, stay in CMP.
- Decided: register eq, lt and taken, then go to DONE.
- taken by funct3:
  - BEQ = eq; BNE = !eq.
  - BLT and BLTU = lt; BGE and BGEU = !lt.
  - 010 and 011 give taken = 0. The comparison still runs, and eq/lt are still reported.
- taken, eq and lt hold their last value until the next decision. They are not cleared by accepting a new start.
- start during CMP is ignored. It is neither queued nor restarting.
- start during DONE is accepted. This gives back-to-back operation with no IDLE bubble.

## Timing
- Reset values: state IDLE, busy 0, done 0, taken 0, eq 0, lt 0, latched operands 0.
- An asserted rst aborts any comparison immediately. No done pulse follows.
- Latency from the accepting edge E0:
  - Let k = 1 + index of the first differing slice, or k = NCHUNK if the operands are equal.
  - DONE is entered at edge Ek, so done is high in the cycle after Ek.
  - WIDTH=32, CHUNK=8: minimum 1 cycle, maximum 4 cycles.
- busy is high from the cycle after E0 through the cycle before DONE.
- CHUNK == WIDTH gives a fixed 1-cycle latency.

## Configuration
- BRCMP_EARLY_EXIT_EN defined: the block terminates at the first differing slice (latency k as above).
- BRCMP_EARLY_EXIT_EN undefined:
  - The block always runs all NCHUNK slices; the first differing slice is recorded and later slices are ignored.
  - Latency is a constant NCHUNK cycles.
  - Results are identical to the early-exit build.

## Test plan
- BEQ, rd1 = rd2 = 0x12345678 -> done 4 cycles after start; taken=1, eq=1, lt=0.
- BLT, rd1 = 0xFFFFFFFF (-1), rd2 = 0x00000001 -> taken=1, lt=1.
  - With early exit, done comes 1 cycle after start.
- BLTU with the same operands -> taken=0, lt=0.
- BGEU, rd1 = 0x00000100, rd2 = 0x000000FF -> taken=1.
  - Decided at slice 2: done after 3 cycles (early exit) or 4 cycles (no early exit).
- Handshake cases:
  - start held high during CMP is ignored.
  - start high in DONE with BNE, 5 vs 5 -> back-to-back accept; second result taken=0, eq=1.
  - funct3 = 010 -> taken=0.
- rst asserted during the second CMP cycle -> outputs drop to 0 asynchronously, state IDLE, no done pulse.
  - The next start completes normally.
